// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: input synchronisation, run/pause/adjust FSM and
// MM:SS BCD time-keeping with display blink masks. Single clock, no derived clocks.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_PAUSE  | time frozen; btn_pause edge starts the watch
// ST_RUN    | 1 Hz events (every 2nd clk_2Hz edge) advance MM:SS
// ST_ADJUST | each clk_2Hz edge bumps the selected field; no carry
module stopwatch_ctrl #(
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_2Hz,
  input  logic       clk_5Hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);

  localparam logic [1:0] ST_PAUSE  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  // Bit positions in the synchroniser bundle
  localparam int I_2HZ = 0;
  localparam int I_5HZ = 1;
  localparam int I_PAU = 2;
  localparam int I_RST = 3;
  localparam int I_ADJ = 4;
  localparam int I_SEL = 5;

  logic [5:0] in_raw;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [2:0] hist;
  logic [1:0] mask_cnt;
  logic       ev_ok;
  logic       tick_ev;
  logic       pause_ev;
  logic       clr_ev;
  logic       adj_lvl;
  logic       sel_lvl;
  logic       blink_lvl;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       phase;
  logic       phase_nxt;
  logic [7:0] min_nxt;
  logic [7:0] sec_nxt;
  logic       sec_at_max;

  assign in_raw = {sw_sel, sw_adj, btn_reset, btn_pause, clk_5Hz, clk_2Hz};

  // History is only kept for the three inputs that are edge-detected
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
      hist  <= {sync2[I_RST], sync2[I_PAU], sync2[I_2HZ]};
    end
  end

  // Release window: covers the synchroniser refill so a level that was
  // already high at release cannot look like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt <= 2'd3;
    end else if (mask_cnt != 2'd0) begin
      mask_cnt <= mask_cnt - 2'd1;
    end
  end

  assign ev_ok     = (mask_cnt == 2'd0);
  assign tick_ev   = ev_ok & sync2[I_2HZ] & ~hist[0];
  assign pause_ev  = ev_ok & sync2[I_PAU] & ~hist[1];
  assign clr_ev    = ev_ok & sync2[I_RST] & ~hist[2];
  assign adj_lvl   = sync2[I_ADJ];
  assign sel_lvl   = sync2[I_SEL];
  assign blink_lvl = sync2[I_5HZ];

  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == MAX_T && o == MAX_O) begin
      return 8'h00;
    end else if (o == 4'd9) begin
      return {t + 4'd1, 4'd0};
    end else begin
      return {t, o + 4'd1};
    end
  endfunction

  always_comb begin
    state_nxt = state;
    if (adj_lvl) begin
      state_nxt = ST_ADJUST;
    end else if (state == ST_ADJUST) begin
      state_nxt = ST_PAUSE;
    end else if (state == ST_PAUSE && pause_ev) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN && pause_ev) begin
      state_nxt = ST_PAUSE;
    end
  end

  assign sec_at_max = (sec_tens == MAX_T) && (sec_ones == MAX_O);

  // Counting follows the current state, so a tick coincident with a pause
  // press in RUN still lands before the watch stops.
  always_comb begin
    phase_nxt = phase;
    min_nxt   = {min_tens, min_ones};
    sec_nxt   = {sec_tens, sec_ones};
    if (clr_ev) begin
      phase_nxt = 1'b0;
      min_nxt   = 8'h00;
      sec_nxt   = 8'h00;
    end else if (state == ST_RUN && tick_ev) begin
      phase_nxt = ~phase;
      if (phase) begin
        sec_nxt = bcd_inc(sec_tens, sec_ones);
        if (sec_at_max) begin
          min_nxt = bcd_inc(min_tens, min_ones);
        end
      end
    end else if (state == ST_ADJUST && tick_ev) begin
      if (sel_lvl) begin
        sec_nxt = bcd_inc(sec_tens, sec_ones);
      end else begin
        min_nxt = bcd_inc(min_tens, min_ones);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PAUSE;
      phase     <= 1'b0;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      min_tens  <= min_nxt[7:4];
      min_ones  <= min_nxt[3:0];
      sec_tens  <= sec_nxt[7:4];
      sec_ones  <= sec_nxt[3:0];
      running   <= (state_nxt == ST_RUN);
      blank_min <= (state_nxt == ST_ADJUST) & ~sel_lvl & blink_lvl;
      blank_sec <= (state_nxt == ST_ADJUST) &  sel_lvl & blink_lvl;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: each task drives one scenario and checks
// the MM:SS digits, running and blank outputs against hand-computed values.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_2Hz = 1'b0;
  logic       clk_5Hz = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blank_min, blank_sec;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.MAX_VAL(59)) dut (
    .clk(clk), .rst(rst), .clk_2Hz(clk_2Hz), .clk_5Hz(clk_5Hz),
    .btn_pause(btn_pause), .btn_reset(btn_reset), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    clk_2Hz = 1'b1;
    cyc(4);
    clk_2Hz = 1'b0;
    cyc(4);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_pause();
    @(negedge clk);
    btn_pause = 1'b1;
    cyc(4);
    btn_pause = 1'b0;
    cyc(4);
  endtask

  task automatic press_reset();
    @(negedge clk);
    btn_reset = 1'b1;
    cyc(4);
    btn_reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", disp); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++;
    if ({blank_min, blank_sec} !== 2'b00) begin
      errors++; $display("FAIL reset_blank got=%b exp=00", {blank_min, blank_sec});
    end
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_start();
    logic [15:0] exp_t [4];
    exp_t = '{16'h0000, 16'h0001, 16'h0001, 16'h0002};
    @(negedge clk);
    btn_pause = 1'b1;
    cyc(2);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL start_latency_k1 got=%b exp=0", running); end
    cyc(1);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL start_latency_k2 got=%b exp=1", running); end
    btn_pause = 1'b0;
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (disp !== exp_t[i]) begin errors++; $display("FAIL start_tick%0d got=%h exp=%h", i, disp, exp_t[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_t [4];
    exp_t = '{16'h5958, 16'h5959, 16'h5959, 16'h0000};
    sw_sel = 1'b0;
    sw_adj = 1'b1;
    cyc(4);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL wrap_enter_adj got=%b exp=0", running); end
    tick_n(59);
    sw_sel = 1'b1;
    cyc(4);
    tick_n(56);
    sw_adj = 1'b0;
    cyc(4);
    checks++;
    if (disp !== 16'h5958) begin errors++; $display("FAIL wrap_preset got=%h exp=5958", disp); end
    press_pause();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL wrap_run got=%b exp=1", running); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (disp !== exp_t[i]) begin errors++; $display("FAIL wrap_tick%0d got=%h exp=%h", i, disp, exp_t[i]); end
    end
  endtask

  task automatic test_adjust_sec();
    logic [15:0] exp_t [3];
    exp_t = '{16'h1259, 16'h1200, 16'h1201};
    sw_sel = 1'b0;
    sw_adj = 1'b1;
    cyc(4);
    tick_n(12);
    sw_sel = 1'b1;
    cyc(4);
    tick_n(58);
    checks++;
    if (disp !== 16'h1258) begin errors++; $display("FAIL adj_preset got=%h exp=1258", disp); end
    @(negedge clk);
    clk_5Hz = 1'b1;
    cyc(2);
    checks++;
    if (blank_sec !== 1'b0) begin errors++; $display("FAIL adj_blink_k1 got=%b exp=0", blank_sec); end
    cyc(1);
    checks++;
    if ({blank_min, blank_sec} !== 2'b01) begin
      errors++; $display("FAIL adj_blink_sec_on got=%b exp=01", {blank_min, blank_sec});
    end
    clk_5Hz = 1'b0;
    cyc(4);
    checks++;
    if (blank_sec !== 1'b0) begin errors++; $display("FAIL adj_blink_sec_off got=%b exp=0", blank_sec); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (disp !== exp_t[i]) begin errors++; $display("FAIL adj_sec_tick%0d got=%h exp=%h", i, disp, exp_t[i]); end
    end
    sw_sel = 1'b0;
    clk_5Hz = 1'b1;
    cyc(4);
    checks++;
    if ({blank_min, blank_sec} !== 2'b10) begin
      errors++; $display("FAIL adj_blink_min got=%b exp=10", {blank_min, blank_sec});
    end
    clk_5Hz = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_priority();
    press_reset();
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL clr_in_adj got=%h exp=0000", disp); end
    clk_5Hz = 1'b1;
    cyc(4);
    checks++;
    if (blank_min !== 1'b1) begin errors++; $display("FAIL clr_keeps_adj got=%b exp=1", blank_min); end
    clk_5Hz = 1'b0;
    cyc(4);
    tick_n(3);
    sw_sel = 1'b1;
    cyc(4);
    tick_n(7);
    sw_adj = 1'b0;
    cyc(4);
    checks++;
    if (disp !== 16'h0307) begin errors++; $display("FAIL clr_preset got=%h exp=0307", disp); end
    press_pause();
    tick();
    checks++;
    if (disp !== 16'h0307) begin errors++; $display("FAIL clr_half_tick got=%h exp=0307", disp); end
    @(negedge clk);
    btn_reset = 1'b1;
    clk_2Hz = 1'b1;
    cyc(4);
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL clr_priority got=%h exp=0000", disp); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL clr_running got=%b exp=1", running); end
    btn_reset = 1'b0;
    clk_2Hz = 1'b0;
    cyc(4);
    tick();
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL clr_phase_cleared got=%h exp=0000", disp); end
    tick();
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL clr_next_sec got=%h exp=0001", disp); end
  endtask

  task automatic test_pause_hold();
    tick_n(8);
    checks++;
    if (disp !== 16'h0005) begin errors++; $display("FAIL hold_preset got=%h exp=0005", disp); end
    tick();
    press_pause();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL hold_paused got=%b exp=0", running); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (disp !== 16'h0005) begin errors++; $display("FAIL hold_tick%0d got=%h exp=0005", i, disp); end
    end
    press_pause();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL hold_resume got=%b exp=1", running); end
    tick();
    checks++;
    if (disp !== 16'h0006) begin errors++; $display("FAIL hold_after_resume got=%h exp=0006", disp); end
  endtask

  task automatic test_back_to_back();
    tick();
    @(negedge clk);
    btn_pause = 1'b1;
    clk_2Hz = 1'b1;
    cyc(4);
    checks++;
    if ({disp, running} !== {16'h0007, 1'b0}) begin
      errors++; $display("FAIL b2b_run_to_pause got=%h/%b exp=0007/0", disp, running);
    end
    btn_pause = 1'b0;
    clk_2Hz = 1'b0;
    cyc(4);
    btn_pause = 1'b1;
    clk_2Hz = 1'b1;
    cyc(4);
    checks++;
    if ({disp, running} !== {16'h0007, 1'b1}) begin
      errors++; $display("FAIL b2b_pause_to_run got=%h/%b exp=0007/1", disp, running);
    end
    btn_pause = 1'b0;
    clk_2Hz = 1'b0;
    cyc(4);
    tick();
    checks++;
    if (disp !== 16'h0007) begin errors++; $display("FAIL b2b_phase got=%h exp=0007", disp); end
    tick();
    checks++;
    if (disp !== 16'h0008) begin errors++; $display("FAIL b2b_count got=%h exp=0008", disp); end
  endtask

  task automatic test_mid_reset();
    sw_sel = 1'b0;
    sw_adj = 1'b1;
    cyc(4);
    tick_n(7);
    sw_sel = 1'b1;
    cyc(4);
    tick_n(22);
    checks++;
    if (disp !== 16'h0730) begin errors++; $display("FAIL mid_preset got=%h exp=0730", disp); end
    @(negedge clk);
    btn_pause = 1'b1;
    clk_2Hz = 1'b1;
    rst = 1'b1;
    sw_adj = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    checks++;
    if ({disp, running, blank_min, blank_sec} !== {16'h0000, 3'b000}) begin
      errors++; $display("FAIL mid_after_release got=%h/%b%b%b exp=0000/000",
                         disp, running, blank_min, blank_sec);
    end
    btn_pause = 1'b0;
    clk_2Hz = 1'b0;
    cyc(4);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL mid_no_spurious got=%b exp=0", running); end
    press_pause();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL mid_restart got=%b exp=1", running); end
    tick_n(2);
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL mid_count got=%h exp=0001", disp); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_wrap();
    test_adjust_sec();
    test_reset_priority();
    test_pause_hold();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
